// File: rtl/fifo_uart_tx_pkg.sv
// Shared types and line-level constants for the FIFO-fed UART transmitter.
// FIFO_UART_TX_PARITY_EN adds the PARITY state to tx_state_t.
package fifo_uart_pkg;

    localparam int DATA_W_DEF = 8;

    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        POP       = 3'd1,
        WAIT_DATA = 3'd2,
        START     = 3'd3,
        DATA      = 3'd4,
        STOP      = 3'd5
`ifdef FIFO_UART_TX_PARITY_EN
        ,
        PARITY    = 3'd6
`endif
    } tx_state_t;

    function automatic logic even_parity(input logic [DATA_W_DEF-1:0] d);
        return ^d;
    endfunction

endpackage

// File: rtl/fifo_uart_tx_if.sv
// FIFO read-side port: one-cycle pop strobe, empty flag and read data.
// master = consumer (drives remove), slave = FIFO.
interface fifo_uart_tx_if #(
    parameter int DATA_W = 8
);
    logic              remove;
    logic              empty;
    logic [DATA_W-1:0] fifo_data;

    modport master (output remove, input empty, input fifo_data);
    modport slave  (input remove, output empty, output fifo_data);
endinterface

// File: rtl/fifo_uart_tx_baud_gen.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1 while run is high, held at 0 otherwise.
// bit_tick marks the last cycle of a bit, pre_tick the cycle just before it.
module uart_baud_gen #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic clk_out,
    input  logic reset,
    input  logic run,
    output logic bit_tick,
    output logic pre_tick
);

    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_PRE  = CNT_W'(CLKS_PER_BIT - 2);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk_out) begin
        if (reset || !run) begin
            cnt <= '0;
        end else if (cnt == CNT_LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    assign bit_tick = run && (cnt == CNT_LAST);
    assign pre_tick = run && (cnt == CNT_PRE);

endmodule

// File: rtl/fifo_uart_tx.sv
// FIFO read client: pops one byte, sends it as start + 8 data LSB-first (+ even parity
// with FIFO_UART_TX_PARITY_EN) + STOP_BITS stop bits. Latency: pop to start bit = RD_LATENCY+1.
// Backpressure: new pop only from IDLE with enable && !empty; a started frame always completes.
module fifo_uart_tx
    import fifo_uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16,
    parameter int DATA_W       = DATA_W_DEF,
    parameter int RD_LATENCY   = 2,
    parameter int STOP_BITS    = 1
) (
    input  logic                  clk_out,
    input  logic                  reset,
    input  logic                  enable,
    fifo_uart_tx_if.master        fifo,
    output logic                  tx,
    output logic                  busy,
    output logic                  byte_done
);

    localparam int WAIT_W = (RD_LATENCY > 1) ? $clog2(RD_LATENCY) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(RD_LATENCY - 1);
    localparam logic [2:0]        BIT_LAST  = 3'(DATA_W - 1);
    localparam logic [2:0]        STOP_LAST = 3'(STOP_BITS - 1);

    tx_state_t         state;
    logic [DATA_W-1:0] shift;
    logic [2:0]        bit_idx;
    logic [WAIT_W-1:0] wait_cnt;
    logic              remove_q;
    logic              run;
    logic              bit_tick;
    logic              pre_tick;
`ifdef FIFO_UART_TX_PARITY_EN
    logic              par_q;
`endif

    // The baud counter only runs while a bit is on the line.
    assign run = (state == START) || (state == DATA) || (state == STOP)
`ifdef FIFO_UART_TX_PARITY_EN
                 || (state == PARITY)
`endif
                 ;

    uart_baud_gen #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_baud (
        .clk_out  (clk_out),
        .reset    (reset),
        .run      (run),
        .bit_tick (bit_tick),
        .pre_tick (pre_tick)
    );

    assign fifo.remove = remove_q;

    always_ff @(posedge clk_out) begin
        if (reset) begin
            state     <= IDLE;
            tx        <= STOP_BIT;
            remove_q  <= 1'b0;
            busy      <= 1'b0;
            byte_done <= 1'b0;
            shift     <= '0;
            bit_idx   <= '0;
            wait_cnt  <= '0;
`ifdef FIFO_UART_TX_PARITY_EN
            par_q     <= 1'b0;
`endif
        end else begin
            remove_q  <= 1'b0;
            byte_done <= 1'b0;
            case (state)
                IDLE: begin
                    tx <= STOP_BIT;
                    if (enable && !fifo.empty) begin
                        state    <= POP;
                        remove_q <= 1'b1;
                        busy     <= 1'b1;
                    end
                end
                POP: begin
                    state    <= WAIT_DATA;
                    wait_cnt <= '0;
                end
                // empty is deliberately ignored here: the pop is already committed.
                WAIT_DATA: begin
                    if (wait_cnt == WAIT_LAST) begin
                        shift <= fifo.fifo_data;
`ifdef FIFO_UART_TX_PARITY_EN
                        par_q <= even_parity(fifo.fifo_data);
`endif
                        state <= START;
                        tx    <= START_BIT;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                START: begin
                    if (bit_tick) begin
                        state   <= DATA;
                        tx      <= shift[0];
                        bit_idx <= '0;
                    end
                end
                DATA: begin
                    if (bit_tick) begin
                        shift <= shift >> 1;
                        if (bit_idx == BIT_LAST) begin
                            bit_idx <= '0;
`ifdef FIFO_UART_TX_PARITY_EN
                            state   <= PARITY;
                            tx      <= par_q;
`else
                            state   <= STOP;
                            tx      <= STOP_BIT;
`endif
                        end else begin
                            bit_idx <= bit_idx + 1'b1;
                            tx      <= shift[1];
                        end
                    end
                end
`ifdef FIFO_UART_TX_PARITY_EN
                PARITY: begin
                    if (bit_tick) begin
                        state <= STOP;
                        tx    <= STOP_BIT;
                    end
                end
`endif
                STOP: begin
                    // Set one cycle early so the registered pulse lands on the last stop cycle.
                    if (pre_tick && (bit_idx == STOP_LAST)) begin
                        byte_done <= 1'b1;
                    end
                    if (bit_tick) begin
                        if (bit_idx == STOP_LAST) begin
                            state   <= IDLE;
                            busy    <= 1'b0;
                            bit_idx <= '0;
                        end else begin
                            bit_idx <= bit_idx + 1'b1;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    tx    <= STOP_BIT;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Bench for fifo_uart_tx: FIFO read model with RD-cycle latency, serial-line decoder and byte scoreboard.
module tb_fifo_uart_tx;
    import fifo_uart_pkg::*;

    localparam int CPB = 4;
    localparam int RD  = 2;
    localparam int SB  = 1;
`ifdef FIFO_UART_TX_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif
    localparam int NBITS = 1 + 8 + PAR + SB;
    localparam int FRAME = NBITS * CPB;

    logic clk_out = 1'b0;
    logic reset   = 1'b1;
    logic enable  = 1'b0;
    logic tx, busy, byte_done;

    fifo_uart_tx_if #(.DATA_W(8)) ifc ();

    fifo_uart_tx #(
        .CLKS_PER_BIT (CPB),
        .DATA_W       (8),
        .RD_LATENCY   (RD),
        .STOP_BITS    (SB)
    ) dut (
        .clk_out   (clk_out),
        .reset     (reset),
        .enable    (enable),
        .fifo      (ifc),
        .tx        (tx),
        .busy      (busy),
        .byte_done (byte_done)
    );

    always #5 clk_out = ~clk_out;

    int total = 0;
    int bad   = 0;
    int cyc = 0, n_remove = 0, n_done = 0, n_both = 0, underflow = 0;

    logic [7:0] fq[$];
    logic [7:0] exp_q[$];
    logic [7:0] rd_pipe [RD];

    // FIFO model: data appears RD cycles after the pop and is valid for one cycle only.
    always @(posedge clk_out) begin
        rd_pipe[0] <= 8'h00;
        if (ifc.remove === 1'b1) begin
            if (fq.size() > 0) rd_pipe[0] <= fq.pop_front();
            else underflow++;
        end
        for (int i = 1; i < RD; i++) rd_pipe[i] <= rd_pipe[i-1];
    end
    assign ifc.fifo_data = rd_pipe[RD-1];

    always @(negedge clk_out) begin
        cyc++;
        ifc.empty = (fq.size() == 0);
        if (ifc.remove === 1'b1) n_remove++;
        if (byte_done === 1'b1) n_done++;
        if (ifc.remove === 1'b1 && byte_done === 1'b1) n_both++;
    end

    task automatic tick();
        @(negedge clk_out);
        #1;
    endtask

    task automatic push_byte(input logic [7:0] d, input bit expect_out);
        fq.push_back(d);
        if (expect_out) exp_q.push_back(d);
    endtask

    function automatic logic [NBITS-1:0] frame_bits(input logic [7:0] d);
        logic [NBITS-1:0] f;
        f = '1;
        f[0] = 1'b0;
        f[8:1] = d;
`ifdef FIFO_UART_TX_PARITY_EN
        f[9] = ^d;
`endif
        return f;
    endfunction

    function automatic logic [7:0] next_exp();
        if (exp_q.size() == 0) return 8'hxx;
        return exp_q.pop_front();
    endfunction

    // Decode one frame: first cycle of each bit gives its value; every cycle must hold it.
    task automatic rx_frame(input int budget, output logic found, output logic [NBITS-1:0] bits,
                            output logic stable, output logic done_ok,
                            output int st_cyc, output int end_cyc);
        found = 1'b0; stable = 1'b1; done_ok = 1'b1; bits = '0; st_cyc = 0; end_cyc = 0;
        for (int i = 0; i < budget && !found; i++) begin
            tick();
            if (tx === 1'b0) found = 1'b1;
        end
        if (found) begin
            st_cyc = cyc;
            for (int k = 0; k < FRAME; k++) begin
                if (k > 0) tick();
                if (k % CPB == 0) bits[k/CPB] = tx;
                else if (tx !== bits[k/CPB]) stable = 1'b0;
                if ((byte_done === 1'b1) != (k == FRAME - 1)) done_ok = 1'b0;
                if (busy !== 1'b1) stable = 1'b0;
            end
            end_cyc = cyc;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; enable = 1'b0;
        repeat (3) tick();
        total++; if (tx !== 1'b1) begin bad++; $display("FAIL reset_tx got=%b want=1", tx); end
        total++; if (ifc.remove !== 1'b0) begin bad++; $display("FAIL reset_remove got=%b want=0", ifc.remove); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
        total++; if (byte_done !== 1'b0) begin bad++; $display("FAIL reset_byte_done got=%b want=0", byte_done); end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_single();
        logic got_rem, found, stable, done_ok;
        logic [NBITS-1:0] bits;
        logic [7:0] e;
        int rem_cyc, st, en;
        got_rem = 1'b0; rem_cyc = 0;
        push_byte(8'hA5, 1'b1);
        enable = 1'b1;
        for (int i = 0; i < 20 && !got_rem; i++) begin
            tick();
            if (ifc.remove === 1'b1) begin got_rem = 1'b1; rem_cyc = cyc; end
        end
        total++; if (!got_rem) begin bad++; $display("FAIL single_remove got=none want=pulse"); end
        tick();
        total++; if (ifc.remove !== 1'b0) begin bad++; $display("FAIL single_remove_width got=%b want=0", ifc.remove); end
        rx_frame(20, found, bits, stable, done_ok, st, en);
        e = next_exp();
        total++; if (!found) begin bad++; $display("FAIL single_start got=none want=start_bit"); end
        total++; if (bits !== frame_bits(e)) begin bad++; $display("FAIL single_bits got=%b want=%b", bits, frame_bits(e)); end
        total++; if (!stable) begin bad++; $display("FAIL single_stable got=glitch want=steady"); end
        total++; if (!done_ok) begin bad++; $display("FAIL single_byte_done got=misplaced want=cycle_%0d", FRAME); end
        total++; if (st - rem_cyc != RD + 1) begin bad++; $display("FAIL single_latency got=%0d want=%0d", st - rem_cyc, RD + 1); end
        total++; if (en - st + 1 != FRAME) begin bad++; $display("FAIL single_frame_len got=%0d want=%0d", en - st + 1, FRAME); end
        tick();
        total++; if (tx !== 1'b1 || busy !== 1'b0) begin bad++; $display("FAIL single_after got=tx%b_busy%b want=tx1_busy0", tx, busy); end
    endtask

    task automatic test_back_to_back();
        logic found, stable, done_ok;
        logic [NBITS-1:0] bits;
        logic [7:0] e;
        int st, en, prev_en, r0, d0;
        r0 = n_remove; d0 = n_done; prev_en = 0;
        push_byte(8'h01, 1'b1);
        push_byte(8'h80, 1'b1);
        push_byte(8'hFF, 1'b1);
        for (int j = 0; j < 3; j++) begin
            rx_frame(40, found, bits, stable, done_ok, st, en);
            e = next_exp();
            total++; if (!found || bits !== frame_bits(e)) begin bad++; $display("FAIL b2b_bits[%0d] got=%b want=%b", j, bits, frame_bits(e)); end
            total++; if (!stable || !done_ok) begin bad++; $display("FAIL b2b_frame[%0d] got=stable%b_done%b want=11", j, stable, done_ok); end
            if (j > 0) begin
                total++; if (st - prev_en - 1 != 2 + RD) begin bad++; $display("FAIL b2b_gap[%0d] got=%0d want=%0d", j, st - prev_en - 1, 2 + RD); end
            end
            prev_en = en;
        end
        repeat (10) tick();
        total++; if (n_remove - r0 != 3) begin bad++; $display("FAIL b2b_removes got=%0d want=3", n_remove - r0); end
        total++; if (n_done - d0 != 3) begin bad++; $display("FAIL b2b_dones got=%0d want=3", n_done - d0); end
    endtask

    task automatic test_empty_idle();
        int r0, lowcnt, busycnt;
        r0 = n_remove; lowcnt = 0; busycnt = 0;
        enable = 1'b1;
        repeat (100) begin
            tick();
            if (tx !== 1'b1) lowcnt++;
            if (busy !== 1'b0) busycnt++;
        end
        total++; if (n_remove != r0) begin bad++; $display("FAIL empty_remove got=%0d want=0", n_remove - r0); end
        total++; if (lowcnt != 0) begin bad++; $display("FAIL empty_tx got=%0d_low_cycles want=0", lowcnt); end
        total++; if (busycnt != 0) begin bad++; $display("FAIL empty_busy got=%0d_busy_cycles want=0", busycnt); end
        total++; if (underflow != 0) begin bad++; $display("FAIL empty_underflow got=%0d want=0", underflow); end
    endtask

    task automatic test_enable_drop();
        logic found, stable, done_ok;
        logic [NBITS-1:0] bits;
        logic [7:0] e;
        int st, en, r0;
        r0 = n_remove;
        push_byte(8'h3C, 1'b1);
        push_byte(8'h55, 1'b1);
        enable = 1'b1;
        fork
            rx_frame(40, found, bits, stable, done_ok, st, en);
            begin
                logic seen;
                seen = 1'b0;
                for (int i = 0; i < 20 && !seen; i++) begin
                    tick();
                    if (ifc.remove === 1'b1) seen = 1'b1;
                end
                // Land in the second cycle of data bit 3.
                repeat (RD + 1 + 4 * CPB + 1) tick();
                enable = 1'b0;
            end
        join
        e = next_exp();
        total++; if (!found || bits !== frame_bits(e)) begin bad++; $display("FAIL drop_bits got=%b want=%b", bits, frame_bits(e)); end
        total++; if (!stable || !done_ok) begin bad++; $display("FAIL drop_frame got=stable%b_done%b want=11", stable, done_ok); end
        repeat (30) tick();
        total++; if (n_remove - r0 != 1) begin bad++; $display("FAIL drop_no_pop got=%0d want=1", n_remove - r0); end
        total++; if (busy !== 1'b0 || tx !== 1'b1) begin bad++; $display("FAIL drop_idle got=busy%b_tx%b want=busy0_tx1", busy, tx); end
        enable = 1'b1;
        rx_frame(40, found, bits, stable, done_ok, st, en);
        e = next_exp();
        total++; if (!found || bits !== frame_bits(e)) begin bad++; $display("FAIL drop_resume_bits got=%b want=%b", bits, frame_bits(e)); end
        total++; if (n_remove - r0 != 2) begin bad++; $display("FAIL drop_resume_pops got=%0d want=2", n_remove - r0); end
    endtask

    task automatic test_reset_mid();
        logic seen, found, stable, done_ok;
        logic [NBITS-1:0] bits;
        logic [7:0] e;
        int st, en, r0, d0, lowcnt;
        seen = 1'b0; lowcnt = 0;
        push_byte(8'h96, 1'b0);
        enable = 1'b1;
        for (int i = 0; i < 20 && !seen; i++) begin
            tick();
            if (ifc.remove === 1'b1) seen = 1'b1;
        end
        total++; if (!seen) begin bad++; $display("FAIL rstmid_remove got=none want=pulse"); end
        // Second cycle of data bit 5.
        repeat (RD + 1 + 6 * CPB + 1) tick();
        r0 = n_remove; d0 = n_done;
        reset = 1'b1;
        tick();
        total++; if (tx !== 1'b1) begin bad++; $display("FAIL rstmid_tx got=%b want=1", tx); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL rstmid_busy got=%b want=0", busy); end
        total++; if (dut.state !== IDLE) begin bad++; $display("FAIL rstmid_state got=%0d want=%0d", dut.state, IDLE); end
        reset = 1'b0;
        repeat (60) begin
            tick();
            if (tx !== 1'b1) lowcnt++;
        end
        total++; if (n_done != d0) begin bad++; $display("FAIL rstmid_no_done got=%0d want=0", n_done - d0); end
        total++; if (n_remove != r0 || lowcnt != 0) begin bad++; $display("FAIL rstmid_no_repop got=pops%0d_low%0d want=0_0", n_remove - r0, lowcnt); end
        push_byte(8'h42, 1'b1);
        rx_frame(40, found, bits, stable, done_ok, st, en);
        e = next_exp();
        total++; if (!found || bits !== frame_bits(e) || !done_ok) begin bad++; $display("FAIL rstmid_recover got=%b want=%b", bits, frame_bits(e)); end
    endtask

`ifdef FIFO_UART_TX_PARITY_EN
    task automatic test_parity();
        logic found, stable, done_ok;
        logic [NBITS-1:0] bits;
        logic [7:0] e;
        int st, en;
        push_byte(8'h07, 1'b1);
        enable = 1'b1;
        rx_frame(40, found, bits, stable, done_ok, st, en);
        e = next_exp();
        total++; if (!found || bits !== frame_bits(e)) begin bad++; $display("FAIL parity_bits got=%b want=%b", bits, frame_bits(e)); end
        total++; if (bits[9] !== 1'b1) begin bad++; $display("FAIL parity_bit got=%b want=1", bits[9]); end
        total++; if (en - st + 1 != 44 || !done_ok) begin bad++; $display("FAIL parity_len got=%0d want=44", en - st + 1); end
    endtask
`endif

    task automatic test_invariants();
        total++; if (n_both != 0) begin bad++; $display("FAIL remove_with_done got=%0d want=0", n_both); end
        total++; if (underflow != 0) begin bad++; $display("FAIL pop_of_empty got=%0d want=0", underflow); end
        total++; if (exp_q.size() != 0) begin bad++; $display("FAIL scoreboard_left got=%0d want=0", exp_q.size()); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_empty_idle();
        test_enable_drop();
        test_reset_mid();
`ifdef FIFO_UART_TX_PARITY_EN
        test_parity();
`endif
        test_invariants();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
